// File: rtl/pipe_reg_pkg.sv
// Shared constants and elaboration helpers for the elastic pipeline register.
package pipe_reg_pkg;

  // Deepest pipeline this block is built and checked for.
  localparam int DEPTH_MAX = 8;

  // Width of the occupancy counter: it must be able to hold 0..depth.
  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Legal stage counts are 1..DEPTH_MAX.
  function automatic bit depth_ok(input int depth);
    return (depth >= 1) && (depth <= DEPTH_MAX);
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One pipeline stage: a valid bit plus a data register.
// Data only loads when the incoming word is valid, so a bubble moving
// through the stage leaves the previous data visible.
module pipe_reg_stage #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Stage register: async reset, clear beats load, load copies upstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= INIT;
    end else if (clr) begin
      valid <= 1'b0;
      data  <= INIT;
    end else if (en) begin
      valid <= in_valid;
      if (in_valid) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_reg_ce_arst.sv
// DEPTH-stage elastic pipeline register with clock enable, async reset,
// synchronous clear and an occupancy count.
//
// Handshake: a word moves in when I_VALID & I_READY at a rising CLK edge,
// and moves out when O_VALID & O_READY & CE & ~CLR at that edge. I_READY
// depends combinationally on O_READY so a full pipe that is draining can
// accept a new word in the same cycle. Consumers must qualify the output
// transfer with CE and CLR too, since neither moves data when asserted.
module pipe_reg_ce_arst
  import pipe_reg_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter int               DEPTH = 2,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                        CLK,
  input  logic                        ASYNCRESET,
  input  logic                        CE,
  input  logic                        CLR,
  input  logic                        I_VALID,
  input  logic [WIDTH-1:0]            I,
  output logic                        I_READY,
  output logic                        O_VALID,
  output logic [WIDTH-1:0]            O,
  input  logic                        O_READY,
  output logic [count_w(DEPTH)-1:0]   COUNT
);

  localparam int CW = count_w(DEPTH);

  generate
    if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("pipe_reg_ce_arst: DEPTH must be in 1..8");
    end
  endgenerate

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] load;
  logic             out_xfer;
  logic             in_xfer;
  logic [CW-1:0]    count_q;

  assign O_VALID  = v[DEPTH-1];
  assign O        = d[DEPTH-1];
  assign out_xfer = v[DEPTH-1] & O_READY & CE & ~CLR;
  assign I_READY  = CE & ~CLR & ~ASYNCRESET & load[0];
  assign in_xfer  = I_VALID & I_READY;
  assign COUNT    = count_q;

  // Ready chain from the output back: a stage may load if it is empty or
  // the stage after it is moving, which lets bubbles collapse.
  always_comb begin
    load = '0;
    load[DEPTH-1] = ~v[DEPTH-1] | out_xfer;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      load[k] = ~v[k] | load[k+1];
    end
  end

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_first
        pipe_reg_stage #(.WIDTH(WIDTH), .INIT(INIT)) u_stage (
          .clk      (CLK),
          .rst      (ASYNCRESET),
          .en       (CE & load[k]),
          .clr      (CLR),
          .in_valid (in_xfer),
          .in_data  (I),
          .valid    (v[k]),
          .data     (d[k])
        );
      end else begin : g_next
        pipe_reg_stage #(.WIDTH(WIDTH), .INIT(INIT)) u_stage (
          .clk      (CLK),
          .rst      (ASYNCRESET),
          .en       (CE & load[k]),
          .clr      (CLR),
          .in_valid (v[k-1]),
          .in_data  (d[k-1]),
          .valid    (v[k]),
          .data     (d[k])
        );
      end
    end
  endgenerate

  // Occupancy: +1 on input-only transfer, -1 on output-only transfer.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      count_q <= '0;
    end else if (CLR) begin
      count_q <= '0;
    end else if (CE) begin
      if (in_xfer && !out_xfer) begin
        count_q <= count_q + CW'(1);
      end else if (!in_xfer && out_xfer) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_reg_ce_arst.sv
// Bench for pipe_reg_ce_arst (DEPTH=3, INIT=16'hA5A5): directed scenarios
// plus randomized traffic, checked every cycle against a position model.
module tb_pipe_reg_ce_arst;

  localparam int          W      = 16;
  localparam int          D      = 3;
  localparam int          CW     = 2;
  localparam logic [15:0] INIT_V = 16'hA5A5;

  logic          CLK;
  logic          ASYNCRESET;
  logic          CE;
  logic          CLR;
  logic          I_VALID;
  logic [W-1:0]  I;
  logic          I_READY;
  logic          O_VALID;
  logic [W-1:0]  O;
  logic          O_READY;
  logic [CW-1:0] COUNT;

  pipe_reg_ce_arst #(.WIDTH(W), .DEPTH(D), .INIT(INIT_V)) dut (
    .CLK        (CLK),
    .ASYNCRESET (ASYNCRESET),
    .CE         (CE),
    .CLR        (CLR),
    .I_VALID    (I_VALID),
    .I          (I),
    .I_READY    (I_READY),
    .O_VALID    (O_VALID),
    .O          (O),
    .O_READY    (O_READY),
    .COUNT      (COUNT)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Words are kept front-first with the stage they sit in. Each edge a
  // word steps forward if the slot ahead of it is free (after the words in
  // front have moved), and the head leaves on an output transfer.
  typedef struct {
    int          pos;
    logic [15:0] data;
  } item_t;

  item_t       m_q[$];
  logic [15:0] m_o = INIT_V;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  function automatic bit head_valid();
    return (m_q.size() > 0) && (m_q[0].pos == D - 1);
  endfunction

  function automatic bit slot0_free(input bit leave);
    int lim = D;
    for (int i = (leave ? 1 : 0); i < m_q.size(); i++) begin
      int np;
      np  = (m_q[i].pos + 1 < lim) ? m_q[i].pos + 1 : m_q[i].pos;
      lim = np;
    end
    return lim > 0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_o = INIT_V;
  endtask

  task automatic model_step();
    bit leave;
    bit rdy;
    int lim;
    leave = head_valid() & O_READY & CE & !CLR;
    rdy   = CE & !CLR & slot0_free(leave);
    if (CLR) begin
      model_reset();
    end else if (CE) begin
      if (leave) begin
        void'(m_q.pop_front());
        void'(exp_q.pop_front());
      end
      lim = D;
      for (int i = 0; i < m_q.size(); i++) begin
        item_t t;
        int    np;
        t  = m_q[i];
        np = (t.pos + 1 < lim) ? t.pos + 1 : t.pos;
        if (np == D - 1 && t.pos != D - 1) m_o = t.data;
        t.pos  = np;
        m_q[i] = t;
        lim    = np;
      end
      if (I_VALID && rdy) begin
        item_t n;
        n.pos  = 0;
        n.data = I;
        m_q.push_back(n);
        exp_q.push_back(I);
        if (D == 1) m_o = I;
      end
    end
  endtask

  // Model advances on the same events as the design.
  always @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) model_reset();
    else            model_step();
  end

  // Compare process: every falling edge, outputs against the model.
  always @(negedge CLK) begin
    if (started) begin
      if (ASYNCRESET) begin
        check("rst_o", O, INIT_V);
        check("rst_o_valid", O_VALID, 0);
        check("rst_count", COUNT, 0);
        check("rst_i_ready", I_READY, 0);
      end else begin
        bit leave;
        leave = head_valid() & O_READY & CE & !CLR;
        check("i_ready", I_READY, CE & !CLR & slot0_free(leave));
        check("o_valid", O_VALID, head_valid());
        check("o", O, m_o);
        check("count", COUNT, m_q.size());
        if (leave) begin
          if (exp_q.size() == 0) check("order_underflow", 1, 0);
          else                   check("order", O, exp_q[0]);
          got_q.push_back(O);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit ce, input bit clr, input bit iv,
                       input logic [W-1:0] data, input bit ordy);
    CE      = ce;
    CLR     = clr;
    I_VALID = iv;
    I       = data;
    O_READY = ordy;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_clear();
    drive(1, 1, 0, '0, 1);
    tick();
    got_q.delete();
  endtask

  task automatic check_got4(input string name, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] e);
    logic [15:0] want [4];
    want = '{a, b, c, e};
    check({name, "_len"}, got_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) check(name, got_q[i], want[i]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ASYNCRESET = 1'b0;
    drive(0, 0, 0, '0, 0);

    // Reset applied mid-cycle, before any clock edge.
    #3 ASYNCRESET = 1'b1;
    CE = 1'b1;
    #1;
    check("lit_rst_o", O, 16'hA5A5);
    check("lit_rst_o_valid", O_VALID, 0);
    check("lit_rst_count", COUNT, 0);
    check("lit_rst_i_ready", I_READY, 0);
    started = 1'b1;
    #8 ASYNCRESET = 1'b0;
    tick();

    // Streaming 1..4 with O_READY high.
    drive(1, 0, 1, 16'd1, 1);
    check("lit_empty_i_ready", I_READY, 1);
    tick();
    drive(1, 0, 1, 16'd2, 1); tick();
    drive(1, 0, 1, 16'd3, 1); tick();
    check("lit_stream_o_valid", O_VALID, 1);
    check("lit_stream_o", O, 16'd1);
    drive(1, 0, 1, 16'd4, 1); tick();
    check("lit_stream_count", COUNT, 3);
    check("lit_stream_o2", O, 16'd2);
    for (int i = 0; i < 4; i++) begin drive(1, 0, 0, '0, 1); tick(); end
    check_got4("lit_stream_order", 16'd1, 16'd2, 16'd3, 16'd4);

    // Back-pressure: fill, then release with pass-through ready.
    do_clear();
    drive(1, 0, 1, 16'd5, 0); tick();
    drive(1, 0, 1, 16'd6, 0); tick();
    drive(1, 0, 1, 16'd7, 0); tick();
    drive(1, 0, 1, 16'd8, 0);
    #1;
    check("lit_full_i_ready", I_READY, 0);
    check("lit_full_count", COUNT, 3);
    check("lit_full_o", O, 16'd5);
    tick();
    drive(1, 0, 1, 16'd8, 1);
    #1;
    check("lit_passthru_i_ready", I_READY, 1);
    tick();
    for (int i = 0; i < 4; i++) begin drive(1, 0, 0, '0, 1); tick(); end
    check_got4("lit_bp_order", 16'd5, 16'd6, 16'd7, 16'd8);

    // CE freeze in the middle of a stream.
    do_clear();
    drive(1, 0, 1, 16'd10, 1); tick();
    drive(1, 0, 1, 16'd11, 1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 16'd12, 1);
      #1;
      check("lit_freeze_i_ready", I_READY, 0);
      check("lit_freeze_count", COUNT, 2);
      tick();
    end
    drive(1, 0, 1, 16'd12, 1); tick();
    drive(1, 0, 1, 16'd13, 1); tick();
    for (int i = 0; i < 4; i++) begin drive(1, 0, 0, '0, 1); tick(); end
    check_got4("lit_freeze_order", 16'd10, 16'd11, 16'd12, 16'd13);

    // Clear beats CE=0 and a pending input word.
    do_clear();
    drive(1, 0, 1, 16'd20, 0); tick();
    drive(1, 0, 1, 16'd21, 0); tick();
    check("lit_clr_pre_count", COUNT, 2);
    drive(0, 1, 1, 16'd22, 0);
    #1;
    check("lit_clr_i_ready", I_READY, 0);
    tick();
    check("lit_clr_count", COUNT, 0);
    check("lit_clr_o", O, 16'hA5A5);
    check("lit_clr_o_valid", O_VALID, 0);

    // Bubbles collapse while the output is stalled.
    do_clear();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, (i % 2 == 0), 16'd30 + 16'(i), 0);
      #1;
      check("lit_bubble_i_ready", I_READY, 1);
      tick();
    end
    check("lit_bubble_count", COUNT, 2);
    drive(1, 0, 1, 16'd40, 0); tick();
    check("lit_bubble_full", COUNT, 3);
    drive(1, 0, 1, 16'd41, 0);
    #1;
    check("lit_bubble_i_ready_full", I_READY, 0);
    tick();

    // Randomized traffic with occasional clears and mid-cycle resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        drive(1, 0, 1, 16'($urandom), 1);
        #2 ASYNCRESET = 1'b1;
        #1;
        check("rand_rst_count", COUNT, 0);
        check("rand_rst_o", O, 16'hA5A5);
        #4 ASYNCRESET = 1'b0;
        tick();
      end else begin
        drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0),
              1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 9) < 7));
        tick();
      end
    end

    drive(1, 0, 0, '0, 1);
    for (int i = 0; i < D + 2; i++) tick();
    check("final_drained", COUNT, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
